// File: rtl/io_port_ctrl_if.sv
// CPU-side IN/OUT request bus plus the four device-side byte handshakes of io_port_ctrl.
interface io_port_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 cpu_rd;
    logic                 cpu_wr;
    logic [1:0]           cpu_port;
    logic [WIDTH-1:0]     cpu_wdata;
    logic [WIDTH-1:0]     cpu_rdata;
    logic                 cpu_stall;
    logic [4*WIDTH-1:0]   in_data;
    logic [3:0]           in_valid;
    logic [3:0]           in_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic                 clr_err;
    logic                 err_timeout;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_port, cpu_wdata, in_data, in_valid, out_ready, clr_err,
        output cpu_rdata, cpu_stall, in_ready, out_data, out_valid, err_timeout
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_port, cpu_wdata, in_data, in_valid, out_ready, clr_err,
        input  cpu_rdata, cpu_stall, in_ready, out_data, out_valid, err_timeout
    );
endinterface

// File: rtl/io_port_ctrl.sv
// Handshaked I/O port controller: one byte buffer per input and output port, CPU stall on
// not-ready ports. Define IO_TIMEOUT_EN to build the bounded-wait abort and err_timeout.
module io_port_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic           clk,
    input logic           reset,
    io_port_ctrl_if.slave bus
);
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("io_port_ctrl: TIMEOUT must be in 1..255");
    end

    logic [3:0][WIDTH-1:0] in_buf_q, in_buf_d;
    logic [3:0][WIDTH-1:0] out_buf_q, out_buf_d;
    logic [3:0]            in_full_q, in_full_d;
    logic [3:0]            out_full_q, out_full_d;

    logic op_rd, op_wr, rd_hit, wr_hit, blocked, abort;

    // Read wins when both strobes are high.
    always_comb begin
        op_rd   = bus.cpu_rd;
        op_wr   = bus.cpu_wr & ~bus.cpu_rd;
        rd_hit  = op_rd & in_full_q[bus.cpu_port];
        wr_hit  = op_wr & ~out_full_q[bus.cpu_port];
        blocked = ~reset & ((op_rd & ~in_full_q[bus.cpu_port]) |
                            (op_wr & out_full_q[bus.cpu_port]));
    end

    assign bus.cpu_stall = blocked & ~abort;
    assign bus.cpu_rdata = rd_hit ? in_buf_q[bus.cpu_port] : '0;
    assign bus.in_ready  = ~in_full_q & {4{~reset}};
    assign bus.out_valid = out_full_q;
    assign bus.out_data  = out_buf_q;

    // Slots freed or filled at an edge are seen by the other side only next cycle.
    always_comb begin
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        for (int p = 0; p < 4; p++) begin
            if (bus.in_valid[p] && !in_full_q[p]) begin
                in_buf_d[p]  = bus.in_data[p*WIDTH +: WIDTH];
                in_full_d[p] = 1'b1;
            end
            if (bus.out_ready[p] && out_full_q[p]) begin
                out_full_d[p] = 1'b0;
            end
        end
        if (rd_hit) begin
            in_full_d[bus.cpu_port] = 1'b0;
        end
        if (wr_hit) begin
            out_buf_d[bus.cpu_port]  = bus.cpu_wdata;
            out_full_d[bus.cpu_port] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_buf_q   <= '0;
            in_full_q  <= '0;
            out_buf_q  <= '0;
            out_full_q <= '0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitIn  = 2'd1;
    localparam logic [1:0] StWaitOut = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] port_q;
    logic [7:0] wait_cnt_q, wait_cnt_d, cnt_cur;
    logic       same_req, err_q, err_d;

    // A change of operation or port restarts the count from this cycle.
    assign same_req = (port_q == bus.cpu_port) &&
                      ((state_q == StWaitIn && op_rd) || (state_q == StWaitOut && op_wr));
    assign cnt_cur  = same_req ? wait_cnt_q : 8'd0;
    assign abort    = blocked && (cnt_cur == 8'(TIMEOUT));

    always_comb begin
        state_d    = StIdle;
        wait_cnt_d = 8'd0;
        err_d      = err_q;
        if (blocked && !abort) begin
            state_d    = op_rd ? StWaitIn : StWaitOut;
            wait_cnt_d = cnt_cur + 8'd1;
        end
        if (abort) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            port_q     <= 2'd0;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= bus.cpu_port;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    // Without the abort the stall is fully described by the buffer flags.
    assign abort           = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl; abort checks follow IO_TIMEOUT_EN.
module tb_io_port_ctrl;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    io_port_ctrl_if #(.WIDTH(WIDTH)) bus ();

    io_port_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.cpu_rd    = 1'b1;
        bus.cpu_wr    = 1'b0;
        bus.cpu_port  = 2'd1;
        bus.cpu_wdata = '0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = '0;
        bus.clr_err   = 1'b0;

        // Reset state, with a read pending that must not stall.
        @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 4'h0);
        check("rst_stall", bus.cpu_stall, 1'b0);
        check("rst_rdata", bus.cpu_rdata, 8'h00);
        check("rst_out_valid", bus.out_valid, 4'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_err", bus.err_timeout, 1'b0);
        bus.cpu_rd = 1'b0;
        reset      = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 4'hF);

        // Push 0xA5 on port 2, read it the next cycle.
        bus.in_data[2*8 +: 8] = 8'hA5;
        bus.in_valid          = 4'b0100;
        cyc();
        bus.in_valid = '0;
        bus.cpu_rd   = 1'b1;
        bus.cpu_port = 2'd2;
        #1;
        check("t1_ready_low", bus.in_ready, 4'b1011);
        check("t1_stall", bus.cpu_stall, 1'b0);
        check("t1_rdata", bus.cpu_rdata, 8'hA5);
        cyc();
        bus.cpu_rd = 1'b0;
        #1;
        check("t1_ready_back", bus.in_ready, 4'hF);
        check("t1_rdata_idle", bus.cpu_rdata, 8'h00);

        // Read empty port 1; byte arrives 5 cycles later.
        bus.cpu_rd            = 1'b1;
        bus.cpu_port          = 2'd1;
        bus.in_data[1*8 +: 8] = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i == 5) ? 4'b0010 : 4'b0000;
            #1;
            check($sformatf("t2_stall_%0d", i), bus.cpu_stall, 1'b1);
            check($sformatf("t2_rdata0_%0d", i), bus.cpu_rdata, 8'h00);
            cyc();
        end
        bus.in_valid = '0;
        #1;
        check("t2_done_stall", bus.cpu_stall, 1'b0);
        check("t2_done_rdata", bus.cpu_rdata, 8'h3C);
        cyc();
        bus.cpu_rd = 1'b0;
        #1;
        check("t2_ready_after", bus.in_ready, 4'hF);

        // Two writes of 0x7E to port 0 with the device not ready.
        bus.cpu_wr    = 1'b1;
        bus.cpu_port  = 2'd0;
        bus.cpu_wdata = 8'h7E;
        #1;
        check("t3_w1_stall", bus.cpu_stall, 1'b0);
        cyc();
        #1;
        check("t3_valid", bus.out_valid, 4'b0001);
        check("t3_data", bus.out_data[7:0], 8'h7E);
        check("t3_w2_stall", bus.cpu_stall, 1'b1);
        cyc();
        bus.out_ready = 4'b0001;
        #1;
        check("t3_drain_stall", bus.cpu_stall, 1'b1);
        cyc();
        bus.out_ready = '0;
        #1;
        check("t3_drained", bus.out_valid, 4'b0000);
        check("t3_w2_go", bus.cpu_stall, 1'b0);
        cyc();
        bus.cpu_wr = 1'b0;
        #1;
        check("t3_valid2", bus.out_valid, 4'b0001);
        check("t3_data2", bus.out_data[7:0], 8'h7E);
        bus.out_ready = 4'b0001;
        cyc();
        bus.out_ready = '0;
        #1;
        check("t3_empty", bus.out_valid, 4'b0000);
        check("t3_buf_kept", bus.out_data[7:0], 8'h7E);

        // Push into a full port 3 is blocked until a read frees it.
        bus.in_data[3*8 +: 8] = 8'h42;
        bus.in_valid          = 4'b1000;
        cyc();
        bus.in_data[3*8 +: 8] = 8'h99;
        #1;
        check("t4_blocked", bus.in_ready, 4'b0111);
        cyc();
        bus.cpu_rd   = 1'b1;
        bus.cpu_port = 2'd3;
        #1;
        check("t4_rd_first", bus.cpu_rdata, 8'h42);
        check("t4_still_blk", bus.in_ready, 4'b0111);
        cyc();
        bus.cpu_rd = 1'b0;
        #1;
        check("t4_freed", bus.in_ready, 4'hF);
        cyc();
        bus.in_valid = '0;
        bus.cpu_rd   = 1'b1;
        #1;
        check("t4_rd_second", bus.cpu_rdata, 8'h99);
        cyc();
        bus.cpu_rd = 1'b0;

        // Read of empty port 3: abort or unbounded stall.
        bus.cpu_rd   = 1'b1;
        bus.cpu_port = 2'd3;
`ifdef IO_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            check($sformatf("t5_stall_%0d", i), bus.cpu_stall, 1'b1);
            cyc();
        end
        #1;
        check("t5_abort_stall", bus.cpu_stall, 1'b0);
        check("t5_abort_rdata", bus.cpu_rdata, 8'h00);
        check("t5_err_pre", bus.err_timeout, 1'b0);
        cyc();
        bus.cpu_rd = 1'b0;
        #1;
        check("t5_err_set", bus.err_timeout, 1'b1);
        cyc();
        #1;
        check("t5_err_sticky", bus.err_timeout, 1'b1);
        bus.clr_err = 1'b1;
        cyc();
        bus.clr_err = 1'b0;
        #1;
        check("t5_err_clr", bus.err_timeout, 1'b0);
        // clr_err held through a second abort: the set wins.
        bus.cpu_rd  = 1'b1;
        bus.clr_err = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc();
        end
        #1;
        check("t5b_abort", bus.cpu_stall, 1'b0);
        cyc();
        bus.cpu_rd = 1'b0;
        #1;
        check("t5b_set_wins", bus.err_timeout, 1'b1);
        cyc();
        bus.clr_err = 1'b0;
        #1;
        check("t5b_cleared", bus.err_timeout, 1'b0);
`else
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            #1;
            check($sformatf("t5_stall_%0d", i), bus.cpu_stall, 1'b1);
            cyc();
        end
        #1;
        check("t5_no_err", bus.err_timeout, 1'b0);
        bus.cpu_rd = 1'b0;
        #1;
        check("t5_release", bus.cpu_stall, 1'b0);
`endif

        // Simultaneous read and write on port 0: read wins.
        bus.in_data[0*8 +: 8] = 8'h11;
        bus.in_valid          = 4'b0001;
        cyc();
        bus.in_valid  = '0;
        bus.cpu_rd    = 1'b1;
        bus.cpu_wr    = 1'b1;
        bus.cpu_port  = 2'd0;
        bus.cpu_wdata = 8'h55;
        #1;
        check("t6_rdata", bus.cpu_rdata, 8'h11);
        check("t6_stall", bus.cpu_stall, 1'b0);
        cyc();
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        #1;
        check("t6_no_write", bus.out_valid, 4'b0000);
        check("t6_in_freed", bus.in_ready, 4'hF);

        // Reset during a stalled write on port 1.
        bus.cpu_wr            = 1'b1;
        bus.cpu_port          = 2'd1;
        bus.cpu_wdata         = 8'h66;
        bus.in_data[2*8 +: 8] = 8'h77;
        bus.in_valid          = 4'b0100;
        cyc();
        bus.in_valid = '0;
        #1;
        check("t7_stalled", bus.cpu_stall, 1'b1);
        cyc();
        reset = 1'b1;
        #1;
        check("t7_rst_stall", bus.cpu_stall, 1'b0);
        check("t7_rst_valid", bus.out_valid, 4'h0);
        check("t7_rst_ready", bus.in_ready, 4'h0);
        cyc();
        reset = 1'b0;
        #1;
        check("t7_in_empty", bus.in_ready, 4'hF);
        check("t7_out_empty", bus.out_valid, 4'h0);
        check("t7_retry_go", bus.cpu_stall, 1'b0);
        cyc();
        bus.cpu_wr = 1'b0;
        #1;
        check("t7_retry_valid", bus.out_valid, 4'b0010);
        check("t7_retry_data", bus.out_data[15:8], 8'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
